dual_core_mem_arbiter: RTL and testbench
========================================

Name: dual_core_mem_arbiter

Overview:
Arbitrates the single shared memory bus between the two DLX cores (P0, P1), each driven by its own MAC_STATE_MACHINE AS_N/WR_N/ACK_N handshake. Grants one core at a time with round-robin fairness. Holds the grant across back-to-back transactions while the owner asserts lock, which keeps atomic read-modify-write sequences indivisible. Includes an ACK watchdog so a dead memory cannot hang both cores.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
TIMEOUT, 255, max cycles in BUSY without mem_ACK_N before abort
LOCK_MAX, 63, max idle cycles a locked owner may sit in HOLD before forced release

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
c0_AS_N  in  1  core0 address strobe, active-low request
c0_WR_N  in  1  core0 write strobe (0=write)
c0_lock  in  1  core0 atomic sequence in progress
c0_addr  in  ADDR_W  core0 address
c0_dout  in  DATA_W  core0 write data
c0_ACK_N  out  1  core0 acknowledge, active-low
c1_AS_N, c1_WR_N, c1_lock, c1_addr, c1_dout, c1_ACK_N  same as core0, for core1
mem_AS_N  out  1  memory address strobe
mem_WR_N  out  1  memory write strobe
mem_addr  out  ADDR_W  muxed address
mem_dout  out  DATA_W  muxed write data
mem_ACK_N  in  1  memory acknowledge, active-low
grant  out  2  one-hot owner {c1,c0}; 00 = no owner
timeout_err  out  1  one-cycle pulse on watchdog abort
ARB_STATE_OUT  out  2  IDLE=0, BUSY=1, REL=2, HOLD=3

Behaviour:
- Reset (async, reset=0): state IDLE, grant=00, last_owner=1 (so core0 wins the first tie), counters=0, mem_AS_N=1, mem_WR_N=1, c0_ACK_N=c1_ACK_N=1, timeout_err=0. mem_addr and mem_dout are 0 when grant=00.
- Bus outputs:
  - mem_AS_N, mem_WR_N, mem_addr and mem_dout are combinational muxes of the owner's signals, and only in BUSY. Otherwise AS_N and WR_N are 1.
  - Owner's ACK_N = mem_ACK_N in BUSY, else 1.
  - Non-owner's ACK_N = 1 always, so its MAC stalls.
- IDLE:
  - If exactly one core has AS_N=0, grant it next cycle and go to BUSY.
  - If both request, grant the core != last_owner.
  - Arbitration latency: request sampled at edge N, mem_AS_N=0 from cycle N+1.
- BUSY:
  - The watchdog counter increments each cycle.
  - mem_ACK_N=0 at an edge: go to REL and clear the counter.
  - Counter reaches TIMEOUT with no ACK:
    - pulse timeout_err for one cycle;
    - owner ACK_N stays 1;
    - grant goes to 00 and last_owner is set to the aborted core;
    - return to IDLE, dropping lock.
- REL: wait for the owner to raise AS_N.
  - If the owner's lock=1, go to HOLD with grant kept.
  - If lock=0, go to IDLE, set last_owner = owner, grant=00.
  - If AS_N is still 0, stay in REL (the MAC handshake completes).
- HOLD:
  - Owner AS_N=0: go to BUSY with no re-arbitration and no extra cycle. The other core's request is ignored.
  - Owner lock=0 and AS_N=1: go to IDLE and release as in REL.
  - LOCK_MAX cycles in HOLD with no new request: force release to IDLE. lock is ignored until the owner deasserts and reasserts it.
- Simultaneous events:
  - Lock release and a new request by the same owner in the same cycle: the request wins and the grant is kept.
  - Both request in IDLE on the first cycle after reset: core0 wins.
- A request that appears while the arbiter is in BUSY, REL or HOLD for the other core waits, with its AS_N held low by its MAC.
- Reset mid-transaction: immediate abort. Outputs return to their reset values asynchronously.
- Widths: the counters are sized by $clog2 of TIMEOUT+1 and LOCK_MAX+1 and saturate, never wrap.

Decomposition:
- Shared package: state encodings (ARB_IDLE/BUSY/REL/HOLD), grant one-hot constants, default TIMEOUT and LOCK_MAX.
- One natural sub-module, arb_watchdog_cnt: a saturating counter with clear/enable/hit output, instantiated twice (BUSY timeout, HOLD limit).
- Bus muxing and the FSM live in the top.

Test Plan:
- Single requester: c0_AS_N=0 at cycle 2, mem_ACK_N=0 at cycle 5.
  - Required: grant=01 at cycle 3, mem_AS_N=0 cycles 3-5, c0_ACK_N=0 at 5, c1_ACK_N=1 throughout, IDLE after c0_AS_N rises.
- Tie after reset: both AS_N=0 at the same time.
  - Required: core0 served first, then core1 immediately after release.
  - A following tie is won by core0 again only if core1 owned last. Alternation is verified over 4 rounds.
- Atomic sequence: c0_lock=1 with read then write, and c1_AS_N=0 held throughout.
  - Required: grant stays 01 across both transfers (REL->HOLD->BUSY), c1_ACK_N=1 until c0_lock=0, then grant=10.
- Watchdog: mem_ACK_N held 1 for 255 cycles in BUSY.
  - Required: timeout_err=1 for exactly one cycle, grant=00, state IDLE, and a pending core1 request is granted next.
- Lock starvation: c1 holds lock=1 idle in HOLD for 63 cycles while c0 requests.
  - Required: forced release, then grant=01.
- Async reset asserted mid-BUSY.
  - Required: mem_AS_N=1, grant=00 and both ACK_N=1 without waiting for a clock edge. After reset deasserts, the state is IDLE.

Source files
------------

// File: rtl/dual_core_mem_arbiter_pkg.sv
// rtl/dual_core_mem_arbiter_pkg.sv - shared state encodings, grant constants and defaults
package dual_core_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_BUSY = 2'd1,
    ARB_REL  = 2'd2,
    ARB_HOLD = 2'd3
  } arb_state_e;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_C0   = 2'b01;
  localparam logic [1:0] GRANT_C1   = 2'b10;

  localparam int DEF_ADDR_W   = 32;
  localparam int DEF_DATA_W   = 32;
  localparam int DEF_TIMEOUT  = 255;
  localparam int DEF_LOCK_MAX = 63;

  // owner index 0 = core0, 1 = core1
  function automatic logic [1:0] grant_of(input logic owner);
    return owner ? GRANT_C1 : GRANT_C0;
  endfunction

endpackage

// File: rtl/dual_core_mem_arbiter_if.sv
// rtl/dual_core_mem_arbiter_if.sv - core, memory and status signals of the arbiter
interface dual_core_mem_arbiter_if
  import dual_core_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);
  logic              c0_AS_N;
  logic              c0_WR_N;
  logic              c0_lock;
  logic [ADDR_W-1:0] c0_addr;
  logic [DATA_W-1:0] c0_dout;
  logic              c0_ACK_N;
  logic              c1_AS_N;
  logic              c1_WR_N;
  logic              c1_lock;
  logic [ADDR_W-1:0] c1_addr;
  logic [DATA_W-1:0] c1_dout;
  logic              c1_ACK_N;
  logic              mem_AS_N;
  logic              mem_WR_N;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_dout;
  logic              mem_ACK_N;
  logic [1:0]        grant;
  logic              timeout_err;
  logic [1:0]        ARB_STATE_OUT;

  modport slave (
    input  c0_AS_N, c0_WR_N, c0_lock, c0_addr, c0_dout,
    input  c1_AS_N, c1_WR_N, c1_lock, c1_addr, c1_dout,
    input  mem_ACK_N,
    output c0_ACK_N, c1_ACK_N, mem_AS_N, mem_WR_N, mem_addr, mem_dout,
    output grant, timeout_err, ARB_STATE_OUT
  );

  modport master (
    output c0_AS_N, c0_WR_N, c0_lock, c0_addr, c0_dout,
    output c1_AS_N, c1_WR_N, c1_lock, c1_addr, c1_dout,
    output mem_ACK_N,
    input  c0_ACK_N, c1_ACK_N, mem_AS_N, mem_WR_N, mem_addr, mem_dout,
    input  grant, timeout_err, ARB_STATE_OUT
  );
endinterface

// File: rtl/dual_core_mem_arbiter_arb_watchdog_cnt.sv
// rtl/dual_core_mem_arbiter_arb_watchdog_cnt.sv - saturating cycle counter with clear/enable/hit
module arb_watchdog_cnt #(
  parameter int MAX = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_hit
);
  localparam int W = (MAX < 2) ? 1 : $clog2(MAX + 1);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != W'(MAX))) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  // hit marks the edge at which the count reaches MAX
  assign o_hit = i_en && (r_cnt == W'(MAX - 1));
endmodule

// File: rtl/dual_core_mem_arbiter.sv
// rtl/dual_core_mem_arbiter.sv - round-robin shared memory bus arbiter for two DLX cores
// with lock-held ownership, ACK watchdog and HOLD starvation limit.
module dual_core_mem_arbiter
  import dual_core_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int TIMEOUT  = DEF_TIMEOUT,
  parameter int LOCK_MAX = DEF_LOCK_MAX
) (
  input logic                   clk,
  input logic                   reset,
  dual_core_mem_arbiter_if.slave bus
);
  arb_state_e  r_state, w_state_nx;
  logic [1:0]  r_grant, w_grant_nx;
  logic        r_last_owner, w_last_nx;
  logic [1:0]  r_lock_blk, w_blk_set;
  logic        r_to_err, w_to_pulse;

  logic              w_owner;
  logic              w_own_as_n;
  logic              w_own_wr_n;
  logic              w_own_lock;
  logic [ADDR_W-1:0] w_own_addr;
  logic [DATA_W-1:0] w_own_dout;
  logic              w_busy;
  logic              w_to_hit;
  logic              w_hold_hit;

  assign w_owner    = r_grant[1];
  assign w_own_as_n = w_owner ? bus.c1_AS_N : bus.c0_AS_N;
  assign w_own_wr_n = w_owner ? bus.c1_WR_N : bus.c0_WR_N;
  assign w_own_addr = w_owner ? bus.c1_addr : bus.c0_addr;
  assign w_own_dout = w_owner ? bus.c1_dout : bus.c0_dout;
  // a lock forced off by the HOLD limit stays ignored until the core drops it
  assign w_own_lock = w_owner ? (bus.c1_lock & ~r_lock_blk[1])
                              : (bus.c0_lock & ~r_lock_blk[0]);
  assign w_busy     = (r_state == ARB_BUSY);

  arb_watchdog_cnt #(.MAX(TIMEOUT)) u_busy_wd (
    .clk   (clk),
    .rst_n (reset),
    .i_clr (r_state != ARB_BUSY),
    .i_en  (r_state == ARB_BUSY),
    .o_hit (w_to_hit)
  );

  arb_watchdog_cnt #(.MAX(LOCK_MAX)) u_hold_wd (
    .clk   (clk),
    .rst_n (reset),
    .i_clr (r_state != ARB_HOLD),
    .i_en  (r_state == ARB_HOLD),
    .o_hit (w_hold_hit)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= ARB_IDLE;
      r_grant      <= GRANT_NONE;
      r_last_owner <= 1'b1;
      r_lock_blk   <= 2'b00;
      r_to_err     <= 1'b0;
    end else begin
      r_state      <= w_state_nx;
      r_grant      <= w_grant_nx;
      r_last_owner <= w_last_nx;
      r_lock_blk   <= (r_lock_blk & {bus.c1_lock, bus.c0_lock}) | w_blk_set;
      r_to_err     <= w_to_pulse;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_grant_nx = r_grant;
    w_last_nx  = r_last_owner;
    w_blk_set  = 2'b00;
    w_to_pulse = 1'b0;
    case (r_state)
      ARB_IDLE: begin
        if (!bus.c0_AS_N && !bus.c1_AS_N) begin
          w_grant_nx = grant_of(~r_last_owner);
          w_state_nx = ARB_BUSY;
        end else if (!bus.c0_AS_N) begin
          w_grant_nx = GRANT_C0;
          w_state_nx = ARB_BUSY;
        end else if (!bus.c1_AS_N) begin
          w_grant_nx = GRANT_C1;
          w_state_nx = ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        // an ACK on the final watchdog cycle still completes the transfer
        if (!bus.mem_ACK_N) begin
          w_state_nx = ARB_REL;
        end else if (w_to_hit) begin
          w_state_nx = ARB_IDLE;
          w_grant_nx = GRANT_NONE;
          w_last_nx  = w_owner;
          w_to_pulse = 1'b1;
        end
      end
      ARB_REL: begin
        if (w_own_as_n) begin
          if (w_own_lock) begin
            w_state_nx = ARB_HOLD;
          end else begin
            w_state_nx = ARB_IDLE;
            w_grant_nx = GRANT_NONE;
            w_last_nx  = w_owner;
          end
        end
      end
      ARB_HOLD: begin
        if (!w_own_as_n) begin
          w_state_nx = ARB_BUSY;
        end else if (!w_own_lock || w_hold_hit) begin
          w_state_nx = ARB_IDLE;
          w_grant_nx = GRANT_NONE;
          w_last_nx  = w_owner;
          w_blk_set  = w_own_lock ? grant_of(w_owner) : 2'b00;
        end
      end
      default: begin
        w_state_nx = ARB_IDLE;
        w_grant_nx = GRANT_NONE;
      end
    endcase
  end

  assign bus.mem_AS_N      = w_busy ? w_own_as_n : 1'b1;
  assign bus.mem_WR_N      = w_busy ? w_own_wr_n : 1'b1;
  assign bus.mem_addr      = w_busy ? w_own_addr : '0;
  assign bus.mem_dout      = w_busy ? w_own_dout : '0;
  assign bus.c0_ACK_N      = (w_busy && (r_grant == GRANT_C0)) ? bus.mem_ACK_N : 1'b1;
  assign bus.c1_ACK_N      = (w_busy && (r_grant == GRANT_C1)) ? bus.mem_ACK_N : 1'b1;
  assign bus.grant         = r_grant;
  assign bus.timeout_err   = r_to_err;
  assign bus.ARB_STATE_OUT = r_state;
endmodule

// File: tb/tb_dual_core_mem_arbiter.sv
// tb/tb_dual_core_mem_arbiter.sv - directed self-checking bench for dual_core_mem_arbiter
module tb_dual_core_mem_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int n_pass = 0;
  int n_total = 0;

  dual_core_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  dual_core_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(255), .LOCK_MAX(63)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.c0_AS_N = 1'b1; bus.c0_WR_N = 1'b1; bus.c0_lock = 1'b0;
    bus.c1_AS_N = 1'b1; bus.c1_WR_N = 1'b1; bus.c1_lock = 1'b0;
    bus.c0_addr = 32'h0; bus.c0_dout = 32'h0;
    bus.c1_addr = 32'h0; bus.c1_dout = 32'h0;
    bus.mem_ACK_N = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle_inputs();
    #2;
    n_total++; if (bus.ARB_STATE_OUT !== 2'd0) $display("FAIL rst_state: got %0d want 0", bus.ARB_STATE_OUT); else n_pass++;
    n_total++; if (bus.grant !== 2'b00) $display("FAIL rst_grant: got %b want 00", bus.grant); else n_pass++;
    n_total++; if (bus.mem_AS_N !== 1'b1 || bus.mem_WR_N !== 1'b1) $display("FAIL rst_mem_strobes: got %b%b want 11", bus.mem_AS_N, bus.mem_WR_N); else n_pass++;
    n_total++; if (bus.c0_ACK_N !== 1'b1 || bus.c1_ACK_N !== 1'b1) $display("FAIL rst_acks: got %b%b want 11", bus.c0_ACK_N, bus.c1_ACK_N); else n_pass++;
    n_total++; if (bus.timeout_err !== 1'b0 || bus.mem_addr !== 32'h0) $display("FAIL rst_misc: got to=%b addr=%h want 0/0", bus.timeout_err, bus.mem_addr); else n_pass++;
    tick();
    reset = 1'b1;
  endtask

  task automatic test_tie();
    logic [1:0] exp_g;
    bus.c0_addr = 32'h100; bus.c1_addr = 32'h200;
    bus.c0_AS_N = 1'b0; bus.c1_AS_N = 1'b0;
    tick();
    n_total++; if (bus.grant !== 2'b01) $display("FAIL tie_first_grant: got %b want 01", bus.grant); else n_pass++;
    n_total++; if (bus.mem_addr !== 32'h100) $display("FAIL tie_first_addr: got %h want 100", bus.mem_addr); else n_pass++;
    bus.mem_ACK_N = 1'b0;
    #1;
    n_total++; if (bus.c0_ACK_N !== 1'b0 || bus.c1_ACK_N !== 1'b1) $display("FAIL tie_acks: got %b%b want 01", bus.c0_ACK_N, bus.c1_ACK_N); else n_pass++;
    tick();
    n_total++; if (bus.ARB_STATE_OUT !== 2'd2) $display("FAIL tie_rel: got %0d want 2", bus.ARB_STATE_OUT); else n_pass++;
    bus.mem_ACK_N = 1'b1; bus.c0_AS_N = 1'b1;
    tick();
    n_total++; if (bus.ARB_STATE_OUT !== 2'd0 || bus.grant !== 2'b00) $display("FAIL tie_release: got st=%0d g=%b want 0/00", bus.ARB_STATE_OUT, bus.grant); else n_pass++;
    tick();
    n_total++; if (bus.grant !== 2'b10 || bus.mem_addr !== 32'h200) $display("FAIL tie_second: got g=%b addr=%h want 10/200", bus.grant, bus.mem_addr); else n_pass++;
    bus.mem_ACK_N = 1'b0;
    tick();
    bus.mem_ACK_N = 1'b1; bus.c1_AS_N = 1'b1;
    tick();
    for (int r = 0; r < 4; r++) begin
      exp_g = (r % 2 == 0) ? 2'b01 : 2'b10;
      bus.c0_AS_N = 1'b0; bus.c1_AS_N = 1'b0;
      tick();
      n_total++; if (bus.grant !== exp_g) $display("FAIL tie_round%0d: got %b want %b", r, bus.grant, exp_g); else n_pass++;
      if (exp_g == 2'b01) bus.c1_AS_N = 1'b1; else bus.c0_AS_N = 1'b1;
      bus.mem_ACK_N = 1'b0;
      tick();
      bus.mem_ACK_N = 1'b1; bus.c0_AS_N = 1'b1; bus.c1_AS_N = 1'b1;
      tick();
      n_total++; if (bus.grant !== 2'b00) $display("FAIL tie_round%0d_rel: got %b want 00", r, bus.grant); else n_pass++;
    end
  endtask

  task automatic test_single();
    bus.c0_addr = 32'hA5A5_0004; bus.c0_WR_N = 1'b1; bus.c0_AS_N = 1'b0;
    #1;
    n_total++; if (bus.grant !== 2'b00 || bus.mem_AS_N !== 1'b1) $display("FAIL single_latency: got g=%b as=%b want 00/1", bus.grant, bus.mem_AS_N); else n_pass++;
    tick();
    n_total++; if (bus.grant !== 2'b01 || bus.mem_AS_N !== 1'b0) $display("FAIL single_grant: got g=%b as=%b want 01/0", bus.grant, bus.mem_AS_N); else n_pass++;
    n_total++; if (bus.mem_addr !== 32'hA5A5_0004 || bus.mem_WR_N !== 1'b1) $display("FAIL single_bus: got addr=%h wr=%b want a5a50004/1", bus.mem_addr, bus.mem_WR_N); else n_pass++;
    tick();
    n_total++; if (bus.mem_AS_N !== 1'b0 || bus.c0_ACK_N !== 1'b1) $display("FAIL single_wait: got as=%b ack=%b want 0/1", bus.mem_AS_N, bus.c0_ACK_N); else n_pass++;
    tick();
    bus.mem_ACK_N = 1'b0;
    #1;
    n_total++; if (bus.c0_ACK_N !== 1'b0 || bus.c1_ACK_N !== 1'b1 || bus.mem_AS_N !== 1'b0) $display("FAIL single_ack: got c0=%b c1=%b as=%b want 0/1/0", bus.c0_ACK_N, bus.c1_ACK_N, bus.mem_AS_N); else n_pass++;
    tick();
    n_total++; if (bus.ARB_STATE_OUT !== 2'd2 || bus.mem_AS_N !== 1'b1) $display("FAIL single_rel: got st=%0d as=%b want 2/1", bus.ARB_STATE_OUT, bus.mem_AS_N); else n_pass++;
    bus.mem_ACK_N = 1'b1; bus.c0_AS_N = 1'b1;
    tick();
    n_total++; if (bus.ARB_STATE_OUT !== 2'd0 || bus.grant !== 2'b00) $display("FAIL single_idle: got st=%0d g=%b want 0/00", bus.ARB_STATE_OUT, bus.grant); else n_pass++;
  endtask

  task automatic test_atomic();
    bus.c0_lock = 1'b1; bus.c0_WR_N = 1'b1; bus.c0_addr = 32'h40; bus.c0_AS_N = 1'b0;
    tick();
    bus.c1_AS_N = 1'b0; bus.mem_ACK_N = 1'b0;
    tick();
    bus.mem_ACK_N = 1'b1; bus.c0_AS_N = 1'b1;
    tick();
    n_total++; if (bus.ARB_STATE_OUT !== 2'd3 || bus.grant !== 2'b01) $display("FAIL atomic_hold: got st=%0d g=%b want 3/01", bus.ARB_STATE_OUT, bus.grant); else n_pass++;
    tick(); tick();
    n_total++; if (bus.grant !== 2'b01 || bus.c1_ACK_N !== 1'b1) $display("FAIL atomic_hold_wait: got g=%b c1ack=%b want 01/1", bus.grant, bus.c1_ACK_N); else n_pass++;
    // lock drop and new request in the same cycle: request keeps the grant
    bus.c0_AS_N = 1'b0; bus.c0_WR_N = 1'b0; bus.c0_dout = 32'hDEAD_BEEF; bus.c0_lock = 1'b0;
    tick();
    n_total++; if (bus.ARB_STATE_OUT !== 2'd1 || bus.grant !== 2'b01) $display("FAIL atomic_rebusy: got st=%0d g=%b want 1/01", bus.ARB_STATE_OUT, bus.grant); else n_pass++;
    n_total++; if (bus.mem_WR_N !== 1'b0 || bus.mem_dout !== 32'hDEAD_BEEF) $display("FAIL atomic_write: got wr=%b d=%h want 0/deadbeef", bus.mem_WR_N, bus.mem_dout); else n_pass++;
    bus.mem_ACK_N = 1'b0;
    #1;
    n_total++; if (bus.c1_ACK_N !== 1'b1 || bus.c0_ACK_N !== 1'b0) $display("FAIL atomic_acks: got c0=%b c1=%b want 0/1", bus.c0_ACK_N, bus.c1_ACK_N); else n_pass++;
    tick();
    bus.mem_ACK_N = 1'b1; bus.c0_AS_N = 1'b1; bus.c0_WR_N = 1'b1;
    tick();
    n_total++; if (bus.ARB_STATE_OUT !== 2'd0 || bus.grant !== 2'b00) $display("FAIL atomic_release: got st=%0d g=%b want 0/00", bus.ARB_STATE_OUT, bus.grant); else n_pass++;
    tick();
    n_total++; if (bus.grant !== 2'b10) $display("FAIL atomic_c1_after: got %b want 10", bus.grant); else n_pass++;
    bus.mem_ACK_N = 1'b0;
    tick();
    bus.mem_ACK_N = 1'b1; bus.c1_AS_N = 1'b1;
    tick();
  endtask

  task automatic test_watchdog();
    int n_busy;
    logic early;
    n_busy = 1; early = 1'b0;
    bus.c0_AS_N = 1'b0;
    tick();
    n_total++; if (bus.grant !== 2'b01) $display("FAIL wd_grant: got %b want 01", bus.grant); else n_pass++;
    bus.c1_AS_N = 1'b0;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (bus.ARB_STATE_OUT !== 2'd1) break;
      n_busy++;
      if (bus.timeout_err !== 1'b0) early = 1'b1;
    end
    n_total++; if (n_busy != 255 || early) $display("FAIL wd_busy_cycles: got %0d early=%b want 255/0", n_busy, early); else n_pass++;
    n_total++; if (bus.timeout_err !== 1'b1 || bus.grant !== 2'b00 || bus.ARB_STATE_OUT !== 2'd0) $display("FAIL wd_abort: got to=%b g=%b st=%0d want 1/00/0", bus.timeout_err, bus.grant, bus.ARB_STATE_OUT); else n_pass++;
    n_total++; if (bus.c0_ACK_N !== 1'b1) $display("FAIL wd_no_ack: got %b want 1", bus.c0_ACK_N); else n_pass++;
    tick();
    n_total++; if (bus.timeout_err !== 1'b0 || bus.grant !== 2'b10) $display("FAIL wd_next: got to=%b g=%b want 0/10", bus.timeout_err, bus.grant); else n_pass++;
    bus.c0_AS_N = 1'b1; bus.mem_ACK_N = 1'b0;
    tick();
    bus.mem_ACK_N = 1'b1; bus.c1_AS_N = 1'b1;
    tick();
  endtask

  task automatic test_starvation();
    int n_hold;
    n_hold = 1;
    bus.c1_lock = 1'b1; bus.c1_AS_N = 1'b0;
    tick();
    n_total++; if (bus.grant !== 2'b10) $display("FAIL starve_grant: got %b want 10", bus.grant); else n_pass++;
    bus.mem_ACK_N = 1'b0;
    tick();
    bus.mem_ACK_N = 1'b1; bus.c1_AS_N = 1'b1;
    tick();
    n_total++; if (bus.ARB_STATE_OUT !== 2'd3) $display("FAIL starve_hold: got %0d want 3", bus.ARB_STATE_OUT); else n_pass++;
    bus.c0_AS_N = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (bus.ARB_STATE_OUT !== 2'd3) break;
      n_hold++;
    end
    n_total++; if (n_hold != 63) $display("FAIL starve_hold_cycles: got %0d want 63", n_hold); else n_pass++;
    n_total++; if (bus.ARB_STATE_OUT !== 2'd0 || bus.grant !== 2'b00) $display("FAIL starve_release: got st=%0d g=%b want 0/00", bus.ARB_STATE_OUT, bus.grant); else n_pass++;
    tick();
    n_total++; if (bus.grant !== 2'b01) $display("FAIL starve_c0: got %b want 01", bus.grant); else n_pass++;
    bus.mem_ACK_N = 1'b0;
    tick();
    bus.mem_ACK_N = 1'b1; bus.c0_AS_N = 1'b1;
    tick();
    bus.c1_AS_N = 1'b0;
    tick();
    bus.mem_ACK_N = 1'b0;
    tick();
    bus.mem_ACK_N = 1'b1; bus.c1_AS_N = 1'b1;
    tick();
    n_total++; if (bus.ARB_STATE_OUT !== 2'd0 || bus.grant !== 2'b00) $display("FAIL starve_lock_ignored: got st=%0d g=%b want 0/00", bus.ARB_STATE_OUT, bus.grant); else n_pass++;
    bus.c1_lock = 1'b0;
    tick();
  endtask

  task automatic test_async_reset();
    bus.c0_AS_N = 1'b0;
    tick();
    bus.mem_ACK_N = 1'b0;
    #1;
    n_total++; if (bus.c0_ACK_N !== 1'b0 || bus.mem_AS_N !== 1'b0) $display("FAIL arst_pre: got ack=%b as=%b want 0/0", bus.c0_ACK_N, bus.mem_AS_N); else n_pass++;
    #2;
    reset = 1'b0;
    #1;
    n_total++; if (bus.mem_AS_N !== 1'b1 || bus.grant !== 2'b00) $display("FAIL arst_bus: got as=%b g=%b want 1/00", bus.mem_AS_N, bus.grant); else n_pass++;
    n_total++; if (bus.c0_ACK_N !== 1'b1 || bus.c1_ACK_N !== 1'b1) $display("FAIL arst_acks: got %b%b want 11", bus.c0_ACK_N, bus.c1_ACK_N); else n_pass++;
    idle_inputs();
    tick();
    reset = 1'b1;
    tick();
    n_total++; if (bus.ARB_STATE_OUT !== 2'd0 || bus.grant !== 2'b00) $display("FAIL arst_after: got st=%0d g=%b want 0/00", bus.ARB_STATE_OUT, bus.grant); else n_pass++;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: bench did not finish, %0d/%0d so far", n_pass, n_total);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_tie();
    test_single();
    test_atomic();
    test_watchdog();
    test_starvation();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
